gf128_mult_seq: RTL

- Digit-serial GF(2^128) multiplier for the AES-GCM GHASH datapath. It replaces the fully combinational product, which exceeds Basys3 LUT budget.
- Processes DIGIT_W bits of operand A per clock. Area/latency trade-off is set by the parameter.
- Optional accumulate mode computes Y <= (Y xor A)·B, one GHASH block step per operation. The display/top level reads o_result.

---
 rtl/gf128_mult_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/gf128_mult_seq.sv
// Digit-serial GF(2^128) multiplier (GCM bit order) with a GHASH accumulator:
// Y <= (Y ^ A) * B when accumulating, Y <= A * B otherwise.
module gf128_mult_seq #(
    parameter int DIGIT_W = 8
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_accum,
    input  logic         i_clear_acc,
    input  logic [0:127] i_a,
    input  logic [0:127] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [0:127] o_result
);

    localparam int NCYC  = 128 / DIGIT_W;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [0:127] R_POLY = {8'hE1, 120'd0};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [0:127]       x_q;
    logic [0:127]       v_q;
    logic [0:127]       z_q;
    logic [0:127]       acc_q;
    logic               busy_q;
    logic               done_q;
    logic [0:127]       z_next;
    logic [0:127]       v_next;

    // DIGIT_W unrolled shift-and-add iterations; returns {Z, V}.
    function automatic logic [0:255] digit_step(input logic [0:127] z_in,
                                                input logic [0:127] v_in,
                                                input logic [0:DIGIT_W-1] xd);
        logic [0:127] z;
        logic [0:127] v;
        z = z_in;
        v = v_in;
        for (int i = 0; i < DIGIT_W; i++) begin
            if (xd[i])
                z = z ^ v;
            if (v[127])
                v = (v >> 1) ^ R_POLY;
            else
                v = v >> 1;
        end
        return {z, v};
    endfunction

    always_comb begin
        {z_next, v_next} = digit_step(z_q, v_q, x_q[0:DIGIT_W-1]);
    end

    // X is shifted toward index 0 so the current digit always sits at the top.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            x_q    <= '0;
            v_q    <= '0;
            z_q    <= '0;
            acc_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_clear_acc)
                        acc_q <= '0;
                    if (i_start) begin
                        x_q    <= (i_accum && !i_clear_acc) ? (i_a ^ acc_q) : i_a;
                        v_q    <= i_b;
                        z_q    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (i_clear_acc)
                        acc_q <= '0;
                    z_q <= z_next;
                    v_q <= v_next;
                    x_q <= x_q << DIGIT_W;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NCYC - 1)) begin
                        acc_q  <= z_next;
                        cnt    <= '0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = acc_q;

endmodule
